// File: rtl/sram_sp_512x56_pkg.sv
// Shared constants for the 512x56 instruction-cache way SRAM and its cache word packing.
package sram_sp_512x56_pkg;

  localparam int SRAM_DEPTH = 512;
  localparam int SRAM_WIDTH = 56;
  localparam int SRAM_AW    = 9;
  localparam int SRAM_TILES = 7;

  localparam int TAG_BITS  = 23;
  localparam int DATA_BITS = 32;
  localparam int PAD_BITS  = 1;

  // Cache word layout, MSB first: {pad, tag, data}
  function automatic logic [SRAM_WIDTH-1:0] pack_word(input logic [PAD_BITS-1:0]  pad,
                                                      input logic [TAG_BITS-1:0]  tag,
                                                      input logic [DATA_BITS-1:0] data);
    return {pad, tag, data};
  endfunction

endpackage

// File: rtl/sram_sp_512x56_tile.sv
// One 512x8 byte tile: GF180 hard macro when SRAM_GF180_MACRO_EN is defined, else a behavioural
// array with the macro's pin semantics (cen/gwen active low, registered write-first q).
module sram_tile_512x8
  import sram_sp_512x56_pkg::*;
(
`ifdef USE_POWER_PINS
  inout  wire                 VDD,
  inout  wire                 VSS,
`endif
  input  logic                clk,
  input  logic                cen,
  input  logic                gwen,
  input  logic [SRAM_AW-1:0]  addr,
  input  logic [7:0]          d,
  output logic [7:0]          q
);

`ifdef SRAM_GF180_MACRO_EN
  gf180mcu_fd_ip_sram__sram512x8m8wm1 u_macro (
`ifdef USE_POWER_PINS
    .VDD  (VDD),
    .VSS  (VSS),
`endif
    .CLK  (clk),
    .CEN  (cen),
    .GWEN (gwen),
    .WEN  (8'h00),
    .A    (addr),
    .D    (d),
    .Q    (q)
  );
`else
  logic [7:0] mem [0:SRAM_DEPTH-1];

  // A disabled tile (reset) neither writes nor updates q.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!gwen) begin
        mem[addr] <= d;
        q         <= d;
      end else begin
        q <= mem[addr];
      end
    end
  end
`endif

endmodule

// File: rtl/sram_sp_512x56.sv
// 512x56 single-port SRAM built from seven byte tiles; one-cycle read, write-first.
// Build options: SRAM_GF180_MACRO_EN selects GF180 hard macros, USE_POWER_PINS exposes VDD/VSS.
module sram_sp_512x56
  import sram_sp_512x56_pkg::*;
#(
  parameter int DEPTH = SRAM_DEPTH,
  parameter int WIDTH = SRAM_WIDTH
) (
`ifdef USE_POWER_PINS
  inout  wire                VDD,
  inout  wire                VSS,
`endif
  input  logic               clk,
  input  logic               resetn,
  input  logic               we,
  input  logic [SRAM_AW-1:0] addr,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout
);

  localparam int TILES = WIDTH / 8;

  logic             rd_ok;
  logic [WIDTH-1:0] q_raw;
  logic             cen;
  logic             gwen;

  // Tiles are disabled during reset, which drops any coincident write.
  assign cen  = ~resetn;
  assign gwen = ~we;

  for (genvar i = 0; i < TILES; i++) begin : g_tile
    sram_tile_512x8 u_tile (
`ifdef USE_POWER_PINS
      .VDD  (VDD),
      .VSS  (VSS),
`endif
      .clk  (clk),
      .cen  (cen),
      .gwen (gwen),
      .addr (addr),
      .d    (din[8*i +: 8]),
      .q    (q_raw[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) rd_ok <= 1'b0;
    else         rd_ok <= 1'b1;
  end

  // Tile outputs hold stale data across reset; mask until the first valid access.
  assign dout = rd_ok ? q_raw : '0;

endmodule

// File: tb/tb_sram_sp_512x56.sv
// Self-checking bench for sram_sp_512x56 against an array-based reference model.
module tb_sram_sp_512x56;
  import sram_sp_512x56_pkg::*;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  we;
  logic [SRAM_AW-1:0]    addr;
  logic [SRAM_WIDTH-1:0] din;
  logic [SRAM_WIDTH-1:0] dout;

  int vectors = 0;
  int errors  = 0;

  logic [SRAM_WIDTH-1:0] model_mem   [SRAM_DEPTH];
  bit                    model_valid [SRAM_DEPTH];

  always #5 clk = ~clk;

  sram_sp_512x56 dut (
    .clk    (clk),
    .resetn (resetn),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .dout   (dout)
  );

  // Apply one access, let the edge happen, and return the model's view of dout after it.
  task automatic apply(input logic rst_n, input logic w, input logic [SRAM_AW-1:0] a,
                       input logic [SRAM_WIDTH-1:0] d,
                       output logic [SRAM_WIDTH-1:0] exp, output bit known);
    resetn = rst_n; we = w; addr = a; din = d;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp = '0; known = 1'b1;
    end else if (w) begin
      model_mem[a] = d; model_valid[a] = 1'b1;
      exp = d; known = 1'b1;
    end else begin
      exp = model_mem[a]; known = model_valid[a];
    end
  endtask

  task automatic test_reset;
    logic [SRAM_WIDTH-1:0] exp;
    bit known;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 9'd5, 56'hAA, exp, known);
      vectors++;
      if (dout !== 56'h0) begin
        errors++; $display("FAIL reset_hold cyc=%0d dout=%h expected=%h", i, dout, 56'h0);
      end
    end
    resetn = 1'b1; we = 1'b0;
    #2;
    vectors++;
    if (dout !== 56'h0) begin
      errors++; $display("FAIL reset_release_pre_edge dout=%h expected=%h", dout, 56'h0);
    end
    apply(1'b1, 1'b0, 9'd5, '0, exp, known);
    vectors++;
    if (dout === 56'hAA) begin
      errors++; $display("FAIL reset_write_dropped dout=%h expected not %h", dout, 56'hAA);
    end
  endtask

  task automatic test_write_read;
    logic [SRAM_WIDTH-1:0] exp;
    bit known;
    apply(1'b1, 1'b1, 9'h1FF, 56'h00DEADBEEF123456, exp, known);
    apply(1'b1, 1'b0, 9'h1FF, '0, exp, known);
    vectors++;
    if (dout !== 56'h00DEADBEEF123456) begin
      errors++; $display("FAIL write_read_1ff dout=%h expected=%h", dout, 56'h00DEADBEEF123456);
    end
  endtask

  task automatic test_write_first;
    logic [SRAM_WIDTH-1:0] exp;
    bit known;
    apply(1'b1, 1'b1, 9'd3, 56'h12345678ABCDEF, exp, known);
    vectors++;
    if (dout !== 56'h12345678ABCDEF) begin
      errors++; $display("FAIL write_first dout=%h expected=%h", dout, 56'h12345678ABCDEF);
    end
  endtask

  task automatic test_back_to_back;
    logic [SRAM_WIDTH-1:0] exp;
    logic [SRAM_WIDTH-1:0] pat;
    bit known;
    int bad_w = 0, bad_r = 0;
    for (int k = 0; k < SRAM_DEPTH; k++) begin
      pat = SRAM_WIDTH'(k) * 56'h0101_0101_0101;
      apply(1'b1, 1'b1, SRAM_AW'(k), pat, exp, known);
      vectors++;
      if (dout !== pat) begin
        errors++;
        if (bad_w++ < 4) $display("FAIL b2b_write addr=%0d dout=%h expected=%h", k, dout, pat);
      end
    end
    for (int k = 0; k < SRAM_DEPTH; k++) begin
      pat = SRAM_WIDTH'(k) * 56'h0101_0101_0101;
      apply(1'b1, 1'b0, SRAM_AW'(k), '0, exp, known);
      vectors++;
      if (dout !== pat) begin
        errors++;
        if (bad_r++ < 4) $display("FAIL b2b_read addr=%0d dout=%h expected=%h", k, dout, pat);
      end
    end
  endtask

  task automatic test_lanes;
    logic [SRAM_WIDTH-1:0] exp;
    bit known;
    logic [SRAM_WIDTH-1:0] pad_word;
    pad_word = pack_word(1'b1, '0, '0);
    apply(1'b1, 1'b1, 9'd10, 56'h0000000000_00FF, exp, known);
    apply(1'b1, 1'b1, 9'd11, 56'hFF00_0000_0000_00, exp, known);
    apply(1'b1, 1'b1, 9'd12, pad_word, exp, known);
    apply(1'b1, 1'b0, 9'd10, '0, exp, known);
    vectors++;
    if (dout !== 56'h0000000000_00FF) begin
      errors++; $display("FAIL lane0 dout=%h expected=%h", dout, 56'h0000000000_00FF);
    end
    apply(1'b1, 1'b0, 9'd11, '0, exp, known);
    vectors++;
    if (dout !== 56'hFF00_0000_0000_00) begin
      errors++; $display("FAIL lane6 dout=%h expected=%h", dout, 56'hFF00_0000_0000_00);
    end
    apply(1'b1, 1'b0, 9'd12, '0, exp, known);
    vectors++;
    if (dout !== 56'h80_0000_0000_0000) begin
      errors++; $display("FAIL pad_bit dout=%h expected=%h", dout, 56'h80_0000_0000_0000);
    end
  endtask

  task automatic test_reset_mid;
    logic [SRAM_WIDTH-1:0] exp;
    bit known;
    apply(1'b1, 1'b1, 9'd7, 56'h1, exp, known);
    apply(1'b0, 1'b1, 9'd7, 56'h2, exp, known);
    vectors++;
    if (dout !== 56'h0) begin
      errors++; $display("FAIL reset_mid_gate dout=%h expected=%h", dout, 56'h0);
    end
    apply(1'b1, 1'b0, 9'd7, '0, exp, known);
    vectors++;
    if (dout !== 56'h1) begin
      errors++; $display("FAIL reset_mid_keep dout=%h expected=%h", dout, 56'h1);
    end
  endtask

  task automatic test_random;
    logic [SRAM_WIDTH-1:0] exp;
    logic [SRAM_WIDTH-1:0] d;
    logic [SRAM_AW-1:0]    a;
    logic r, w;
    bit known;
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 19) != 0);
      w = $urandom_range(0, 1) != 0;
      a = ($urandom_range(0, 3) == 0) ? SRAM_AW'($urandom) : SRAM_AW'($urandom_range(100, 115));
      d = {$urandom, $urandom};
      apply(r, w, a, d, exp, known);
      if (known) begin
        vectors++;
        if (dout !== exp) begin
          errors++;
          if (bad++ < 6)
            $display("FAIL random i=%0d rst_n=%b we=%b addr=%0d dout=%h expected=%h",
                     i, r, w, a, dout, exp);
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0; we = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < SRAM_DEPTH; i++) model_valid[i] = 1'b0;
    test_reset;
    test_write_read;
    test_write_first;
    test_back_to_back;
    test_lanes;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
